// File: rtl/gpk_prefix_adder.sv
// Pipelined Kogge-Stone adder on g/p/k bit cells with valid/ready backpressure.
// Optional kill_all output (a==0 && b==0) is enabled by defining GPK_PREFIX_ADDER_KILL_EN.
module gpk_prefix_adder #(
    parameter int WIDTH      = 16,
    parameter int PIPE_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef GPK_PREFIX_ADDER_KILL_EN
    ,
    output logic             kill_all
`endif
);

    localparam int L       = $clog2(WIDTH);
    localparam int PE_SAFE = (PIPE_EVERY > 0) ? PIPE_EVERY : 1;
    localparam int NSTAGE  = (PIPE_EVERY > 0) ? (1 + (L + PE_SAFE - 1) / PE_SAFE) : 1;

    // lv_*[l] is the state seen by prefix level l+1 (post-register where a stage boundary sits)
    logic [WIDTH-1:0] lv_g   [0:L];
    logic [WIDTH-1:0] lv_p   [0:L];
    logic [WIDTH-1:0] lv_bp  [0:L];
    logic             lv_cin [0:L];
`ifdef GPK_PREFIX_ADDER_KILL_EN
    logic             lv_kill [0:L];
    logic             kill0_s;
    assign kill0_s = &(~a & ~b);
`endif
    logic [NSTAGE:1]  en_s;
    logic [WIDTH-1:0] g0_s;
    logic [WIDTH-1:0] p0_s;

    assign g0_s = a & b;
    assign p0_s = a ^ b;

    if (PIPE_EVERY > 0) begin : g_s1
        logic [WIDTH-1:0] g_q;
        logic [WIDTH-1:0] p_q;
        logic             cin_q;
`ifdef GPK_PREFIX_ADDER_KILL_EN
        logic             kill_q;
        // Stage-1 kill flag register
        always_ff @(posedge clk or posedge rst) begin
            if (rst)          kill_q <= 1'b0;
            else if (en_s[1]) kill_q <= kill0_s;
        end
        assign lv_kill[0] = kill_q;
`endif
        // Stage-1 bit-cell register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                g_q   <= '0;
                p_q   <= '0;
                cin_q <= 1'b0;
            end else if (en_s[1]) begin
                g_q   <= g0_s;
                p_q   <= p0_s;
                cin_q <= cin;
            end
        end
        assign lv_g[0]   = g_q;
        assign lv_p[0]   = p_q;
        assign lv_bp[0]  = p_q;
        assign lv_cin[0] = cin_q;
    end else begin : g_c0
        assign lv_g[0]   = g0_s;
        assign lv_p[0]   = p0_s;
        assign lv_bp[0]  = p0_s;
        assign lv_cin[0] = cin;
`ifdef GPK_PREFIX_ADDER_KILL_EN
        assign lv_kill[0] = kill0_s;
`endif
    end

    for (genvar l = 1; l <= L; l++) begin : g_lvl
        localparam int D = 1 << (l - 1);
        logic [WIDTH-1:0] g_s;
        logic [WIDTH-1:0] p_s;

        // One Kogge-Stone level: (G,P) o (G',P') at distance D
        always_comb begin
            g_s = lv_g[l-1];
            p_s = lv_p[l-1];
            for (int i = D; i < WIDTH; i++) begin
                g_s[i] = lv_g[l-1][i] | (lv_p[l-1][i] & lv_g[l-1][i-D]);
                p_s[i] = lv_p[l-1][i] & lv_p[l-1][i-D];
            end
        end

        if ((PIPE_EVERY > 0) && ((l % PE_SAFE) == 0) && (l < L)) begin : g_reg
            localparam int S = 1 + l / PE_SAFE;
            logic [WIDTH-1:0] g_q;
            logic [WIDTH-1:0] p_q;
            logic [WIDTH-1:0] bp_q;
            logic             cin_q;
`ifdef GPK_PREFIX_ADDER_KILL_EN
            logic             kill_q;
            // Intermediate kill flag register
            always_ff @(posedge clk or posedge rst) begin
                if (rst)          kill_q <= 1'b0;
                else if (en_s[S]) kill_q <= lv_kill[l-1];
            end
            assign lv_kill[l] = kill_q;
`endif
            // Intermediate prefix-stage register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    g_q   <= '0;
                    p_q   <= '0;
                    bp_q  <= '0;
                    cin_q <= 1'b0;
                end else if (en_s[S]) begin
                    g_q   <= g_s;
                    p_q   <= p_s;
                    bp_q  <= lv_bp[l-1];
                    cin_q <= lv_cin[l-1];
                end
            end
            assign lv_g[l]   = g_q;
            assign lv_p[l]   = p_q;
            assign lv_bp[l]  = bp_q;
            assign lv_cin[l] = cin_q;
        end else begin : g_pass
            assign lv_g[l]   = g_s;
            assign lv_p[l]   = p_s;
            assign lv_bp[l]  = lv_bp[l-1];
            assign lv_cin[l] = lv_cin[l-1];
`ifdef GPK_PREFIX_ADDER_KILL_EN
            assign lv_kill[l] = lv_kill[l-1];
`endif
        end
    end

    logic [WIDTH-1:0] carry_s;
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;

    // cin acts as the group generate of position -1: c[i] = G[i-1:0] | P[i-1:0]&cin
    always_comb begin
        carry_s    = '0;
        carry_s[0] = lv_cin[L];
        for (int i = 1; i < WIDTH; i++) begin
            carry_s[i] = lv_g[L][i-1] | (lv_p[L][i-1] & lv_cin[L]);
        end
    end
    assign sum_s  = lv_bp[L] ^ carry_s;
    assign cout_s = lv_g[L][WIDTH-1] | (lv_p[L][WIDTH-1] & lv_cin[L]);

    if (PIPE_EVERY > 0) begin : g_out
        logic [NSTAGE:1]  v_q;
        logic [NSTAGE:1]  v_d;
        logic [WIDTH-1:0] sum_q;
        logic             cout_q;

        // A stage loads when it or any stage downstream is empty, or the output drains
        for (genvar s = 1; s <= NSTAGE; s++) begin : g_en
            assign en_s[s] = out_ready | ~(&v_q[NSTAGE:s]);
        end

        // Valid-chain next state
        always_comb begin
            v_d = v_q;
            if (en_s[1]) v_d[1] = in_valid;
            else         v_d[1] = v_q[1];
            for (int s = 2; s <= NSTAGE; s++) begin
                if (en_s[s]) v_d[s] = v_q[s-1];
                else         v_d[s] = v_q[s];
            end
        end

        // Valid-chain register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) v_q <= '0;
            else     v_q <= v_d;
        end

        // Final stage: sum/cout register drives the outputs directly
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q  <= '0;
                cout_q <= 1'b0;
            end else if (en_s[NSTAGE]) begin
                sum_q  <= sum_s;
                cout_q <= cout_s;
            end
        end
`ifdef GPK_PREFIX_ADDER_KILL_EN
        logic kill_q;
        // Final-stage kill flag register
        always_ff @(posedge clk or posedge rst) begin
            if (rst)               kill_q <= 1'b0;
            else if (en_s[NSTAGE]) kill_q <= lv_kill[L];
        end
        assign kill_all = kill_q;
`endif
        assign in_ready  = en_s[1];
        assign out_valid = v_q[NSTAGE];
        assign sum       = sum_q;
        assign cout      = cout_q;
    end else begin : g_comb
        assign en_s      = '1;
        assign in_ready  = out_ready;
        assign out_valid = in_valid;
        assign sum       = sum_s;
        assign cout      = cout_s;
`ifdef GPK_PREFIX_ADDER_KILL_EN
        assign kill_all  = lv_kill[L];
`endif
    end

endmodule
